// File: rtl/fifo_ddr_writer.sv
// fifo_ddr_writer: drains bytes from a FIFO read port, packs them little-endian into
// AXI_DATA_WIDTH beats and writes them to memory as fixed-length AXI4 INCR bursts.
// Burst addresses walk upward from BASE_ADDR and wrap inside a REGION_BYTES window.
//
// Ports:
//   rclk, rrst                   clock (FIFO read domain), async active-low reset
//   r_en, empty, data_out        FIFO read side (data_out valid one cycle after r_en)
//   aw*                          AXI4 write-address channel (master)
//   w*                           AXI4 write-data channel (master)
//   bresp, bvalid, bready        AXI4 write-response channel
//   err                          sticky: some burst returned a non-OKAY response
//   busy                         high whenever the FSM is outside IDLE
module fifo_ddr_writer #(
    parameter int unsigned           DATA_WIDTH     = 8,
    parameter int unsigned           AXI_DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           BURST_LEN      = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned           REGION_BYTES   = 4096
) (
    input  logic                        rclk,
    input  logic                        rrst,
    // FIFO read port
    output logic                        r_en,
    input  logic                        empty,
    input  logic [DATA_WIDTH-1:0]       data_out,
    // AXI4 write address
    output logic [ADDR_WIDTH-1:0]       awaddr,
    output logic [7:0]                  awlen,
    output logic [2:0]                  awsize,
    output logic [1:0]                  awburst,
    output logic                        awvalid,
    input  logic                        awready,
    // AXI4 write data
    output logic [AXI_DATA_WIDTH-1:0]   wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] wstrb,
    output logic                        wlast,
    output logic                        wvalid,
    input  logic                        wready,
    // AXI4 write response and status
    input  logic [1:0]                  bresp,
    input  logic                        bvalid,
    output logic                        bready,
    output logic                        err,
    output logic                        busy
);

    localparam int unsigned BPB         = AXI_DATA_WIDTH / DATA_WIDTH;
    localparam int unsigned TOTAL       = BURST_LEN * BPB;
    localparam int unsigned STRB_W      = AXI_DATA_WIDTH / 8;
    localparam int unsigned BURST_BYTES = BURST_LEN * STRB_W;
    localparam int unsigned CW          = $clog2(TOTAL + 1);
    localparam int unsigned IW          = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int unsigned BW          = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StFill = 3'd1;
    localparam logic [2:0] StAw   = 3'd2;
    localparam logic [2:0] StW    = 3'd3;
    localparam logic [2:0] StB    = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         pop_cnt_q, pop_cnt_d;
    logic [CW-1:0]         cap_cnt_q, cap_cnt_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  err_q, err_d;

    // Byte buffer for one whole burst, stored in pop order; contents need no reset.
    logic [DATA_WIDTH-1:0] byte_buf_q [2**IW];

    logic                  last_cap;
    logic [ADDR_WIDTH-1:0] addr_sum;
    logic [ADDR_WIDTH-1:0] next_addr;

    // The FIFO returns data one cycle after the pop, so rd_pend_q marks a byte to capture.
    assign r_en     = (state_q == StFill) && !empty && (pop_cnt_q < CW'(TOTAL));
    assign last_cap = rd_pend_q && (cap_cnt_q == CW'(TOTAL - 1));

    always_comb begin
        addr_sum  = addr_q + ADDR_WIDTH'(BURST_BYTES);
        next_addr = addr_sum;
        if (addr_sum == BASE_ADDR + ADDR_WIDTH'(REGION_BYTES)) begin
            next_addr = BASE_ADDR;
        end
    end

    always_comb begin
        state_d   = state_q;
        pop_cnt_d = pop_cnt_q;
        cap_cnt_d = cap_cnt_q;
        rd_pend_d = r_en;
        beat_d    = beat_q;
        addr_d    = addr_q;
        err_d     = err_q;

        if (r_en) begin
            pop_cnt_d = pop_cnt_q + 1'b1;
        end
        if (rd_pend_q) begin
            cap_cnt_d = cap_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                // Partial bursts simply wait here for more bytes.
                if (last_cap) begin
                    state_d   = StAw;
                    pop_cnt_d = '0;
                    cap_cnt_d = '0;
                end
            end
            StAw: begin
                if (awvalid && awready) begin
                    state_d = StW;
                end
            end
            StW: begin
                if (wvalid && wready) begin
                    if (wlast) begin
                        state_d = StB;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StB: begin
                if (bvalid && bready) begin
                    state_d = StIdle;
                    addr_d  = next_addr;
                    if (bresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            state_q   <= StIdle;
            pop_cnt_q <= '0;
            cap_cnt_q <= '0;
            rd_pend_q <= 1'b0;
            beat_q    <= '0;
            addr_q    <= BASE_ADDR;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pop_cnt_q <= pop_cnt_d;
            cap_cnt_q <= cap_cnt_d;
            rd_pend_q <= rd_pend_d;
            beat_q    <= beat_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge rclk) begin
        if (rd_pend_q) begin
            byte_buf_q[cap_cnt_q[IW-1:0]] <= data_out;
        end
    end

    // First popped byte of a beat lands in the least significant lane.
    always_comb begin
        wdata = '0;
        for (int unsigned i = 0; i < BPB; i++) begin
            wdata[i*DATA_WIDTH +: DATA_WIDTH] = byte_buf_q[IW'(beat_q * BPB + i)];
        end
    end

    assign awaddr  = addr_q;
    assign awlen   = 8'(BURST_LEN - 1);
    assign awsize  = 3'($clog2(STRB_W));
    assign awburst = 2'b01;
    assign awvalid = (state_q == StAw);
    assign wvalid  = (state_q == StW);
    assign wstrb   = '1;
    assign wlast   = wvalid && (beat_q == BW'(BURST_LEN - 1));
    assign bready  = (state_q == StB);
    assign err     = err_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_ddr_writer.sv
// Directed bench for fifo_ddr_writer: byte FIFO model with one-cycle read latency,
// simple AXI write slave with configurable backpressure, and a protocol monitor.
module tb_fifo_ddr_writer;

    logic        rclk = 1'b0;
    logic        rrst = 1'b0;
    logic        r_en;
    logic        empty;
    logic [7:0]  data_out = 8'h00;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready = 1'b1;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready = 1'b1;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;
    logic        err;
    logic        busy;

    fifo_ddr_writer #(
        .DATA_WIDTH    (8),
        .AXI_DATA_WIDTH(32),
        .ADDR_WIDTH    (32),
        .BURST_LEN     (4),
        .BASE_ADDR     (32'h0),
        .REGION_BYTES  (32)
    ) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .r_en    (r_en),
        .empty   (empty),
        .data_out(data_out),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awsize  (awsize),
        .awburst (awburst),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .err     (err),
        .busy    (busy)
    );

    always #5 rclk = ~rclk;

    int checks = 0;
    int errors = 0;

    // FIFO model
    logic [7:0] mem [256];
    int rptr = 0;
    int wptr = 0;
    logic pop_pending = 1'b0;
    assign empty = (rptr == wptr);

    // Slave configuration
    int   aw_stall = 0;
    int   aw_wait = 0;
    logic wtoggle = 1'b0;
    logic bresp_first_err = 1'b0;

    // Monitor state
    logic [31:0] aw_q [$];
    logic [31:0] w_q [$];
    logic        wl_q [$];
    logic [7:0]  last_awlen;
    logic [2:0]  last_awsize;
    logic [1:0]  last_awburst;
    logic [3:0]  last_wstrb;
    int pop_cnt = 0, pop_empty_cnt = 0, overlap_cnt = 0, aw_unstable = 0, w_unstable = 0;
    int aw_low = 0, b_cnt = 0, gap_bad = 0;
    logic gap_watch = 1'b0;
    logic aw_pend = 1'b0, w_pend = 1'b0;
    logic [31:0] aw_hold_addr, w_hold_data;
    logic w_hold_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge rclk) begin
        #1;
        if (pop_pending) begin
            data_out = mem[rptr];
            rptr++;
            pop_pending = 1'b0;
        end
    end

    always @(posedge rclk) begin
        #1;
        if (awvalid && aw_wait < aw_stall) begin
            awready = 1'b0;
            aw_wait++;
        end else begin
            awready = 1'b1;
            if (!awvalid) aw_wait = 0;
        end
        wready = wtoggle ? !wready : 1'b1;
        bvalid = bready;
        bresp  = (bresp_first_err && b_cnt == 0) ? 2'b10 : 2'b00;
    end

    // Negedge values are exactly what the DUT sees at the next rising edge.
    always @(negedge rclk) begin
        pop_pending = 1'b0;
        if (!rrst) begin
            aw_pend = 1'b0;
            w_pend  = 1'b0;
        end else begin
            if (r_en) begin
                if (empty) pop_empty_cnt++;
                else begin
                    pop_pending = 1'b1;
                    pop_cnt++;
                end
            end
            if (awvalid && wvalid) overlap_cnt++;
            if (aw_pend && (!awvalid || awaddr !== aw_hold_addr)) aw_unstable++;
            if (w_pend && (!wvalid || wdata !== w_hold_data || wlast !== w_hold_last)) w_unstable++;
            if (awvalid && awready) begin
                aw_q.push_back(awaddr);
                last_awlen   = awlen;
                last_awsize  = awsize;
                last_awburst = awburst;
            end
            if (awvalid && !awready) aw_low++;
            aw_pend      = awvalid && !awready;
            aw_hold_addr = awaddr;
            if (wvalid && wready) begin
                w_q.push_back(wdata);
                wl_q.push_back(wlast);
                last_wstrb = wstrb;
            end
            w_pend      = wvalid && !wready;
            w_hold_data = wdata;
            w_hold_last = wlast;
            if (bvalid && bready) b_cnt++;
            if (gap_watch && !(busy && !awvalid && !wvalid && !bready && !r_en)) gap_bad++;
        end
    end

    task automatic push_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wptr] = first + 8'(i);
            wptr++;
        end
    endtask

    task automatic enter_reset();
        rrst = 1'b0;
        repeat (2) @(posedge rclk);
        #1;
        rptr = 0; wptr = 0; pop_pending = 1'b0;
        aw_q.delete(); w_q.delete(); wl_q.delete();
        pop_cnt = 0; pop_empty_cnt = 0; overlap_cnt = 0; aw_unstable = 0; w_unstable = 0;
        aw_low = 0; b_cnt = 0; gap_bad = 0; gap_watch = 1'b0;
        aw_stall = 0; wtoggle = 1'b0; bresp_first_err = 1'b0;
    endtask

    task automatic leave_reset();
        @(posedge rclk);
        #1;
        rrst = 1'b1;
    endtask

    task automatic wait_b(input int n, input int max_cyc, input string tag);
        int cyc = 0;
        while (b_cnt < n && cyc < max_cyc) begin
            @(negedge rclk);
            cyc++;
        end
        check(tag, 64'(b_cnt), 64'(n));
        @(negedge rclk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        enter_reset();
        @(negedge rclk);
        check("rst_awvalid", 64'(awvalid), 64'(0));
        check("rst_wvalid", 64'(wvalid), 64'(0));
        check("rst_wlast", 64'(wlast), 64'(0));
        check("rst_bready", 64'(bready), 64'(0));
        check("rst_r_en", 64'(r_en), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_awaddr", 64'(awaddr), 64'h0);
        leave_reset();
        repeat (5) @(negedge rclk);
        check("idle_empty_busy", 64'(busy), 64'(0));
        check("idle_empty_r_en", 64'(r_en), 64'(0));

        // Basic burst
        enter_reset();
        push_bytes(8'h00, 16);
        leave_reset();
        wait_b(1, 200, "basic_done");
        check("basic_aw_count", 64'(aw_q.size()), 64'(1));
        check("basic_awaddr", 64'(aw_q[0]), 64'h0);
        check("basic_awlen", 64'(last_awlen), 64'(3));
        check("basic_awsize", 64'(last_awsize), 64'(2));
        check("basic_awburst", 64'(last_awburst), 64'(1));
        check("basic_w_count", 64'(w_q.size()), 64'(4));
        check("basic_beat0", 64'(w_q[0]), 64'h03020100);
        check("basic_beat1", 64'(w_q[1]), 64'h07060504);
        check("basic_beat2", 64'(w_q[2]), 64'h0B0A0908);
        check("basic_beat3", 64'(w_q[3]), 64'h0F0E0D0C);
        check("basic_wlast", 64'({wl_q[3], wl_q[2], wl_q[1], wl_q[0]}), 64'b1000);
        check("basic_wstrb", 64'(last_wstrb), 64'hF);
        check("basic_err", 64'(err), 64'(0));
        check("basic_pops", 64'(pop_cnt), 64'(16));
        check("basic_busy_after", 64'(busy), 64'(0));

        // Backpressure on AW and W
        enter_reset();
        aw_stall = 5;
        wtoggle  = 1'b1;
        push_bytes(8'h10, 16);
        leave_reset();
        wait_b(1, 300, "bp_done");
        check("bp_aw_low_cycles", 64'(aw_low), 64'(5));
        check("bp_aw_stable", 64'(aw_unstable), 64'(0));
        check("bp_w_stable", 64'(w_unstable), 64'(0));
        check("bp_overlap", 64'(overlap_cnt), 64'(0));
        check("bp_w_count", 64'(w_q.size()), 64'(4));
        check("bp_beat0", 64'(w_q[0]), 64'h13121110);
        check("bp_beat3", 64'(w_q[3]), 64'h1F1E1D1C);
        check("bp_wlast", 64'({wl_q[3], wl_q[2], wl_q[1], wl_q[0]}), 64'b1000);

        // Starvation mid-fill
        enter_reset();
        push_bytes(8'h20, 10);
        leave_reset();
        repeat (15) @(negedge rclk);
        gap_watch = 1'b1;
        repeat (20) @(negedge rclk);
        gap_watch = 1'b0;
        check("starve_pops", 64'(pop_cnt), 64'(10));
        check("starve_in_fill", 64'(gap_bad), 64'(0));
        check("starve_no_aw", 64'(aw_q.size()), 64'(0));
        @(posedge rclk);
        #1;
        push_bytes(8'h2A, 6);
        wait_b(1, 200, "starve_done");
        check("starve_w_count", 64'(w_q.size()), 64'(4));
        check("starve_beat0", 64'(w_q[0]), 64'h23222120);
        check("starve_beat1", 64'(w_q[1]), 64'h27262524);
        check("starve_beat2", 64'(w_q[2]), 64'h2B2A2928);
        check("starve_beat3", 64'(w_q[3]), 64'h2F2E2D2C);
        check("starve_pops_total", 64'(pop_cnt), 64'(16));
        check("starve_pop_empty", 64'(pop_empty_cnt), 64'(0));

        // Address wrap inside a 32-byte region
        enter_reset();
        push_bytes(8'h30, 48);
        leave_reset();
        wait_b(3, 400, "wrap_done");
        check("wrap_aw_count", 64'(aw_q.size()), 64'(3));
        check("wrap_addr0", 64'(aw_q[0]), 64'h00);
        check("wrap_addr1", 64'(aw_q[1]), 64'h10);
        check("wrap_addr2", 64'(aw_q[2]), 64'h00);
        check("wrap_b3_beat0", 64'(w_q[8]), 64'h53525150);

        // Error response on the first burst only
        enter_reset();
        bresp_first_err = 1'b1;
        push_bytes(8'h60, 32);
        leave_reset();
        wait_b(1, 200, "err_first_done");
        check("err_after_first", 64'(err), 64'(1));
        wait_b(2, 200, "err_second_done");
        check("err_sticky", 64'(err), 64'(1));
        check("err_second_addr", 64'(aw_q[1]), 64'h10);
        check("err_second_beat0", 64'(w_q[4]), 64'h73727170);

        // Reset while the data phase is in progress
        enter_reset();
        push_bytes(8'h80, 16);
        leave_reset();
        for (int cyc = 0; cyc < 200 && w_q.size() < 2; cyc++) begin
            @(posedge rclk);
            #2;
        end
        check("midw_reached", 64'(w_q.size()), 64'(2));
        check("midw_in_w", 64'(wvalid), 64'(1));
        rrst = 1'b0;
        #1;
        check("midw_rst_wvalid", 64'(wvalid), 64'(0));
        check("midw_rst_awvalid", 64'(awvalid), 64'(0));
        check("midw_rst_wlast", 64'(wlast), 64'(0));
        check("midw_rst_bready", 64'(bready), 64'(0));
        check("midw_rst_busy", 64'(busy), 64'(0));
        enter_reset();
        push_bytes(8'h90, 16);
        leave_reset();
        wait_b(1, 200, "midw_next_done");
        check("midw_next_addr", 64'(aw_q[0]), 64'h0);
        check("midw_next_w_count", 64'(w_q.size()), 64'(4));
        check("midw_next_beat0", 64'(w_q[0]), 64'h93929190);
        check("midw_next_beat3", 64'(w_q[3]), 64'h9F9E9D9C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_ddr_writer.md
FIFO_DDR_WRITER -- requirements
Module: fifo_ddr_writer

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 8, FIFO byte width; AXI_DATA_WIDTH, 32, AXI data width (multiple of DATA_WIDTH); ADDR_WIDTH, 32, AXI address width; BURST_LEN, 4, beats per burst (1..16); BASE_ADDR, 0, first write address; REGION_BYTES, 4096, wrap window size (multiple of BURST_LEN*AXI_DATA_WIDTH/8).
REQ-002 SHALL have one clock and an asynchronous, active-low reset: rclk  in  1  clock (FIFO read domain); rrst  in  1  asynchronous active-low reset.
REQ-003 SHALL have FIFO read ports: r_en  out  1  FIFO pop; empty  in  1  FIFO empty; data_out  in  DATA_WIDTH  FIFO read data.
REQ-004 SHALL have AXI4 write-address ports: awaddr  out  ADDR_WIDTH; awlen  out  8; awsize  out  3; awburst  out  2; awvalid  out  1; awready  in  1.
REQ-005 SHALL have AXI4 write-data ports: wdata  out  AXI_DATA_WIDTH; wstrb  out  AXI_DATA_WIDTH/8; wlast  out  1; wvalid  out  1; wready  in  1.
REQ-006 SHALL have AXI4 write-response and status ports: bresp  in  2; bvalid  in  1; bready  out  1; err  out  1  sticky non-OKAY response; busy  out  1  FSM not in IDLE.

Function
REQ-007 SHALL model the FIFO as a 1-cycle read: data_out sampled at edge N+1 belongs to r_en asserted in cycle N.
REQ-008 SHALL assert r_en only when empty=0, state is FILL, and fewer than BURST_LEN*BPB pops (BPB=AXI_DATA_WIDTH/DATA_WIDTH) have been issued for the current burst; back-to-back pops allowed.
REQ-009 SHALL pack bytes little-endian: first popped byte of a beat into wdata[DATA_WIDTH-1:0], BPB-th byte into the MSB lane; beats stored in a BURST_LEN-entry local buffer in pop order.
REQ-010 SHALL implement states IDLE, FILL, AW, W, B.
REQ-011 IDLE -> FILL when empty=0; FILL -> AW on the cycle the final (BURST_LEN*BPB-th) byte is captured; AW -> W on awvalid&&awready; W -> B on wvalid&&wready&&wlast; B -> IDLE on bvalid.
REQ-012 SHALL hold awvalid=1 in AW with awaddr, awlen=BURST_LEN-1, awsize=log2(AXI_DATA_WIDTH/8), awburst=2'b01 stable until accepted.
REQ-013 SHALL in W hold wvalid=1, advance the beat index only on wvalid&&wready, keep wdata stable while wready=0, drive wstrb all ones, and assert wlast only with beat index BURST_LEN-1.
REQ-014 SHALL drive bready=1 only in B.
REQ-015 SHALL on bvalid&&bready set err=1 if bresp!=2'b00; err stays set until reset; the burst is never retried.
REQ-016 SHALL advance the address by BURST_LEN*AXI_DATA_WIDTH/8 at each B handshake; if the result equals BASE_ADDR+REGION_BYTES it SHALL wrap to BASE_ADDR.
REQ-017 SHALL never pop while empty=1; an empty FIFO mid-FILL stalls in FILL with partial data retained, no timeout and no partial burst.
REQ-018 SHALL not assert awvalid and wvalid in the same cycle (address phase strictly precedes data phase).

Reset
REQ-019 SHALL on rrst=0, asynchronously: state IDLE, r_en=0, awvalid=0, wvalid=0, wlast=0, bready=0, err=0, busy=0, awaddr=BASE_ADDR, pop/beat counters 0, buffer contents don't-care.
REQ-020 SHALL on reset assertion mid-burst abandon the burst with no further AXI handshakes and resume from BASE_ADDR after release; bytes already popped are lost.

Verification
REQ-021 Basic burst: 16 bytes 0x00..0x0F preloaded, awready=wready=1, bvalid one cycle after wlast -> one AW at 0x0, awlen=3, awsize=2, beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, wlast on beat 4 only, err=0.
REQ-022 Backpressure: awready low 5 cycles, wready toggling each cycle -> awaddr/wdata stable while unaccepted, exactly 4 W handshakes, no AW/W overlap.
REQ-023 Starvation: 10 bytes then empty for 20 cycles, then 6 more -> exactly 10 pops, state FILL throughout the gap, single burst with correct data after the remaining bytes arrive, no pop while empty=1.
REQ-024 Wrap: REGION_BYTES=32, 48 bytes streamed -> awaddr sequence 0x00, 0x10, 0x00.
REQ-025 Error: bresp=2'b10 on the first burst, OKAY on the second -> err=1 from the first B handshake onward, second burst proceeds at 0x10.
REQ-026 Reset mid-W after beat 2 -> all valids low immediately, next burst after release at BASE_ADDR with fresh data.
